// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: saturating membrane integration of the MAC stream,
// threshold/leak decision on each timestep tick, and a refractory hold after a spike.
module lif_neuron #(
    parameter logic [19:0] THRESH     = 20'd4096,
    parameter int          LEAK_SHIFT = 3,
    parameter int          REFRACT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        inValid,
    input  logic        step,
    output logic        spike,
    output logic        spikeValid,
    output logic [19:0] potential,
    output logic        refractory,
    output logic [7:0]  spikeCount
);

    typedef enum logic {
        INTEGRATE = 1'b0,
        REFRACT_ST = 1'b1
    } state_t;

    localparam logic [19:0] V_MAX = 20'hFFFFF;

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [19:0] v_n;
    logic        spike_n, valid_n;
    logic [7:0]  count_n;
    logic [20:0] sum;
    logic [19:0] nxt, leaked;

    always_comb begin
        sum    = {1'b0, potential} + (inValid ? {5'd0, in} : 21'd0);
        nxt    = sum[20] ? V_MAX : sum[19:0];
        leaked = nxt - (nxt >> LEAK_SHIFT);
    end

    // NOTE: every output of this block is defaulted first, so no path leaves a latch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        v_n     = potential;
        spike_n = 1'b0;
        valid_n = 1'b0;
        count_n = spikeCount;
        case (state)
            INTEGRATE: begin
                if (step) begin
                    valid_n = 1'b1;
                    if (nxt >= THRESH) begin
                        spike_n = 1'b1;
                        v_n     = 20'd0;
                        if (spikeCount != 8'hFF)
                            count_n = spikeCount + 8'd1;
                        if (REFRACT > 0) begin
                            cnt_n   = 8'(REFRACT);
                            state_n = REFRACT_ST;
                        end
                    end else begin
                        v_n = leaked;
                    end
                end else begin
                    v_n = nxt;
                end
            end
            REFRACT_ST: begin
                // Inputs are discarded here, including on the exiting step.
                v_n = 20'd0;
                if (step) begin
                    valid_n = 1'b1;
                    if (cnt == 8'd1) begin
                        cnt_n   = 8'd0;
                        state_n = INTEGRATE;
                    end else begin
                        cnt_n = cnt - 8'd1;
                    end
                end
            end
            default: state_n = INTEGRATE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= INTEGRATE;
            cnt        <= 8'd0;
            potential  <= 20'd0;
            spike      <= 1'b0;
            spikeValid <= 1'b0;
            refractory <= 1'b0;
            spikeCount <= 8'd0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            potential  <= v_n;
            spike      <= spike_n;
            spikeValid <= valid_n;
            refractory <= (state_n == REFRACT_ST);
            spikeCount <= count_n;
        end
    end

endmodule
